// File: rtl/col_beat_packer.sv
// Purpose : packs variable-length MSB-aligned projected rows densely into 128-bit beats
//           for the cache line writer; an explicit flush emits the final partial beat.
// Latency : a row that brings the staged byte count to >= OUT_BYTES gives o_valid the next cycle.
// Backpr. : rows are accepted only in S_ACC with < OUT_BYTES staged; i_ready low holds the beat
//           stable; a row offered while o_ready is low is dropped and sets sticky o_ovf.
//
// Ports:
//   i_clk, i_rst              rising-edge clock, asynchronous active-high reset
//   i_en, i_col_data,         one row per cycle; valid bytes contiguous from the MSB,
//   i_row_bytes               count saturated to IN_BYTES, zero is a no-op
//   i_flush                   end-of-query level, held until o_done
//   o_ready                   a row can be accepted this cycle
//   o_valid/i_ready           beat handshake; o_data first byte in the MSBs, o_keep bit 15 = MSB byte
//   o_last                    final (partial) beat of a flush
//   o_done                    one-cycle pulse when a flush completes
//   o_ovf                     sticky drop flag, cleared only by reset
//   o_row_cnt, o_beat_cnt     accepted-row / beat-handshake counters (COLPACK_STATS_EN only)
//
// Optional feature macro: COLPACK_STATS_EN
module col_beat_packer #(
   parameter int IN_BYTES  = 64,
   parameter int OUT_BYTES = 16,
   parameter int BUF_BYTES = 80
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic [8*IN_BYTES-1:0]       i_col_data,
   input  logic [$clog2(IN_BYTES+1)-1:0] i_row_bytes,
   input  logic                        i_flush,
   output logic                        o_ready,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [8*OUT_BYTES-1:0]      o_data,
   output logic [OUT_BYTES-1:0]        o_keep,
   output logic                        o_last,
   output logic                        o_done,
   output logic                        o_ovf
`ifdef COLPACK_STATS_EN
   ,
   output logic [31:0]                 o_row_cnt,
   output logic [31:0]                 o_beat_cnt
`endif
);

   localparam int IN_W  = 8 * IN_BYTES;
   localparam int OUT_W = 8 * OUT_BYTES;
   localparam int BUF_W = 8 * BUF_BYTES;
   localparam int CNT_W = $clog2(BUF_BYTES + 1);
   localparam int RB_W  = $clog2(IN_BYTES + 1);

   localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_BYTES);
   localparam logic [RB_W-1:0]  IN_MAX  = RB_W'(IN_BYTES);

   typedef enum logic [1:0] {
      S_ACC   = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [RB_W-1:0]    n;
   logic [IN_W-1:0]    row_mask;
   logic [BUF_W-1:0]   row_ext;
   logic [CNT_W-1:0]   cnt_sum;
   logic [OUT_W-1:0]   top;
   logic [OUT_BYTES-1:0] keep_v;
   logic               accept;
   logic               beat_hs;

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   always_comb begin
      n        = (i_row_bytes > IN_MAX) ? IN_MAX : i_row_bytes;
      // Only the first n bytes of the row are merged, so stale bytes below
      // the valid region can never leak into the packed stream.
      row_mask = ~({IN_W{1'b1}} >> {n, 3'b000});
      // Land the row right after the bytes already staged.
      row_ext  = {i_col_data & row_mask, {(BUF_W-IN_W){1'b0}}} >> {cnt_q, 3'b000};
      cnt_sum  = cnt_q + CNT_W'(n);
      top      = buf_q[BUF_W-1 -: OUT_W];
      accept   = i_en && o_ready && (n != '0);
      beat_hs  = o_valid && i_ready;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ACC: begin
            if (accept) begin
               if (cnt_sum >= OUT_CNT) state_d = S_DRAIN;
            end else if (i_flush) begin
               if (cnt_q >= OUT_CNT)  state_d = S_DRAIN;
               else if (cnt_q != '0) state_d = S_FLUSH;
            end
         end
         S_DRAIN: begin
            if (i_ready && ((cnt_q - OUT_CNT) < OUT_CNT)) state_d = S_ACC;
         end
         S_FLUSH: begin
            if (i_ready) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_ACC;
         end
         default: begin
            state_d = S_ACC;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      o_ready = (state_q == S_ACC) && (cnt_q < OUT_CNT) && !i_flush;
      o_valid = (state_q == S_DRAIN) || (state_q == S_FLUSH);
      o_last  = (state_q == S_FLUSH);
      o_done  = done_q;
      o_ovf   = ovf_q;

      case (state_q)
         S_DRAIN: keep_v = {OUT_BYTES{1'b1}};
         S_FLUSH: keep_v = ~({OUT_BYTES{1'b1}} >> cnt_q);
         default: keep_v = '0;
      endcase
      o_keep = keep_v;

      // Bytes outside the keep mask are forced to zero; outside a beat the
      // bus idles at zero.
      o_data = '0;
      for (int b = 0; b < OUT_BYTES; b++) begin
         if (keep_v[b]) o_data[8*b +: 8] = top[8*b +: 8];
      end
   end

   // ------------------------------------------------------------------
   // Buffer, count and flag next-state
   // ------------------------------------------------------------------
   always_comb begin
      buf_d  = buf_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q | (i_en & ~o_ready);
      done_d = 1'b0;

      case (state_q)
         S_ACC: begin
            if (accept) begin
               buf_d = buf_q | row_ext;
               cnt_d = cnt_sum;
            end else if (i_flush && (cnt_q == '0)) begin
               // Nothing staged: the flush completes without a beat.
               done_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (i_ready) begin
               buf_d = buf_q << OUT_W;
               cnt_d = cnt_q - OUT_CNT;
            end
         end
         S_FLUSH: begin
            if (i_ready) begin
               buf_d  = '0;
               cnt_d  = '0;
               done_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

`ifdef COLPACK_STATS_EN
   logic [31:0] row_cnt_q, row_cnt_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      row_cnt_d  = row_cnt_q + 32'(accept);
      beat_cnt_d = beat_cnt_q + 32'(beat_hs);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row_cnt_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         row_cnt_q  <= row_cnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign o_row_cnt  = row_cnt_q;
   assign o_beat_cnt = beat_cnt_q;
`else
   // beat_hs only feeds the statistics counters.
   logic unused_hs;
   assign unused_hs = beat_hs;
`endif

endmodule

// File: tb/tb_col_beat_packer.sv
module tb_col_beat_packer;

   logic         i_clk;
   logic         i_rst;
   logic         i_en;
   logic [511:0] i_col_data;
   logic [6:0]   i_row_bytes;
   logic         i_flush;
   logic         o_ready;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;
   logic [15:0]  o_keep;
   logic         o_last;
   logic         o_done;
   logic         o_ovf;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_hs_cyc = -1;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } beat_t;
   beat_t beats[$];

   col_beat_packer dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_col_data  (i_col_data),
      .i_row_bytes (i_row_bytes),
      .i_flush     (i_flush),
      .o_ready     (o_ready),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_keep      (o_keep),
      .o_last      (o_last),
      .o_done      (o_done),
      .o_ovf       (o_ovf)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Beat collector; only relied on where i_ready is held constant.
   always @(negedge i_clk) begin
      if (o_valid && i_ready) begin
         beats.push_back('{data: o_data, keep: o_keep, last: o_last});
         last_hs_cyc = cyc;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
      $fatal(1, "timeout");
   end

   // Row whose byte k (from the MSB) is start+k for k < n, zero beyond.
   function automatic logic [511:0] seq_row(input logic [7:0] start, input int n);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[511-8*k -: 8] = start + 8'(k);
      return r;
   endfunction

   function automatic logic [127:0] seq_beat(input logic [7:0] start);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = start + 8'(k);
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive_row(input logic [511:0] d, input logic [6:0] nb);
      int t;
      t = 0;
      while (!o_ready && t < 50) begin
         @(negedge i_clk);
         t++;
      end
      n_cmp++;
      if (!o_ready) begin
         n_fail++;
         $display("FAIL drive_row_wait: o_ready=%0b after %0d cycles, required 1", o_ready, t);
      end
      i_en        = 1'b1;
      i_col_data  = d;
      i_row_bytes = nb;
      @(negedge i_clk);
      i_en        = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      n_cmp++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      n_cmp++; if (o_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      n_cmp++; if (o_data !== 128'h0)  begin n_fail++; $display("FAIL rst_data: got %h want 0", o_data); end
      n_cmp++; if (o_keep !== 16'h0)   begin n_fail++; $display("FAIL rst_keep: got %h want 0", o_keep); end
      n_cmp++; if ({o_last, o_done, o_ovf} !== 3'b000)
         begin n_fail++; $display("FAIL rst_flags: last/done/ovf got %b want 000", {o_last, o_done, o_ovf}); end
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_two_rows();
      drive_row(seq_row(8'h01, 8), 7'd8);
      drive_row(seq_row(8'h09, 8), 7'd8);
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL two_rows_valid: got %b want 1", o_valid); end
      n_cmp++; if (o_data !== 128'h0102030405060708090A0B0C0D0E0F10)
         begin n_fail++; $display("FAIL two_rows_data: got %h want 0102030405060708090a0b0c0d0e0f10", o_data); end
      n_cmp++; if (o_keep !== 16'hFFFF) begin n_fail++; $display("FAIL two_rows_keep: got %h want ffff", o_keep); end
      n_cmp++; if (o_last !== 1'b0)     begin n_fail++; $display("FAIL two_rows_last: got %b want 0", o_last); end
      @(negedge i_clk);
      n_cmp++; if ({o_valid, o_ready} !== 2'b01)
         begin n_fail++; $display("FAIL two_rows_after: valid/ready got %b want 01", {o_valid, o_ready}); end
   endtask

   task automatic test_full_row();
      drive_row(seq_row(8'h00, 64), 7'd64);
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if ({o_valid, o_ready} !== 2'b10)
            begin n_fail++; $display("FAIL full_row_vr%0d: valid/ready got %b want 10", k, {o_valid, o_ready}); end
         n_cmp++; if (o_data !== seq_beat(8'(16*k)))
            begin n_fail++; $display("FAIL full_row_beat%0d: got %h want %h", k, o_data, seq_beat(8'(16*k))); end
         @(negedge i_clk);
      end
      n_cmp++; if ({o_valid, o_ready} !== 2'b01)
         begin n_fail++; $display("FAIL full_row_end: valid/ready got %b want 01", {o_valid, o_ready}); end
   endtask

   task automatic test_flush_aligned();
      int t;
      int done_cyc;
      beats.delete();
      for (int r = 0; r < 4; r++) drive_row(seq_row(8'(8'h40 + 12*r), 12), 7'd12);
      i_flush = 1'b1;
      t = 0;
      while (!o_done && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      done_cyc = cyc;
      n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL flush_al_done: got %b want 1", o_done); end
      n_cmp++; if (done_cyc !== last_hs_cyc + 2)
         begin n_fail++; $display("FAIL flush_al_done_time: done at %0d want %0d", done_cyc, last_hs_cyc + 2); end
      i_flush = 1'b0;
      @(negedge i_clk);
      n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL flush_al_pulse: got %b want 0", o_done); end
      n_cmp++; if (beats.size() !== 3)
         begin n_fail++; $display("FAIL flush_al_count: got %0d beats want 3", beats.size()); end
      for (int b = 0; b < beats.size() && b < 3; b++) begin
         n_cmp++; if (beats[b] !== {seq_beat(8'(8'h40 + 16*b)), 16'hFFFF, 1'b0})
            begin n_fail++; $display("FAIL flush_al_beat%0d: got %h/%h/%b want %h/ffff/0", b,
                  beats[b].data, beats[b].keep, beats[b].last, seq_beat(8'(8'h40 + 16*b))); end
      end
   endtask

   task automatic test_partial_flush();
      drive_row(seq_row(8'hA1, 5), 7'd5);
      i_flush = 1'b1;
      @(negedge i_clk);
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL pflush_valid: got %b want 1", o_valid); end
      n_cmp++; if (o_data !== 128'hA1A2A3A4A50000000000000000000000)
         begin n_fail++; $display("FAIL pflush_data: got %h want a1a2a3a4a50000000000000000000000", o_data); end
      n_cmp++; if (o_keep !== 16'hF800) begin n_fail++; $display("FAIL pflush_keep: got %h want f800", o_keep); end
      n_cmp++; if (o_last !== 1'b1)     begin n_fail++; $display("FAIL pflush_last: got %b want 1", o_last); end
      @(negedge i_clk);
      n_cmp++; if ({o_done, o_valid} !== 2'b10)
         begin n_fail++; $display("FAIL pflush_done: done/valid got %b want 10", {o_done, o_valid}); end
      i_flush = 1'b0;
      @(negedge i_clk);
      n_cmp++; if ({o_done, o_ready, o_valid} !== 3'b010)
         begin n_fail++; $display("FAIL pflush_after: done/ready/valid got %b want 010", {o_done, o_ready, o_valid}); end
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      n_cmp++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_init: got %b want 0", o_ovf); end
      drive_row(seq_row(8'h80, 16), 7'd16);
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if ({o_valid, o_data} !== {1'b1, seq_beat(8'h80)})
            begin n_fail++; $display("FAIL bp_hold%0d: valid/data got %b/%h want 1/%h", i, o_valid, o_data, seq_beat(8'h80)); end
         if (i == 3) begin
            i_en = 1'b1; i_col_data = seq_row(8'h55, 16); i_row_bytes = 7'd16;
         end
         if (i == 4) begin
            i_en = 1'b0;
            n_cmp++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_set: got %b want 1", o_ovf); end
         end
         @(negedge i_clk);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      n_cmp++; if ({o_valid, o_ready, o_ovf} !== 3'b011)
         begin n_fail++; $display("FAIL bp_release: valid/ready/ovf got %b want 011", {o_valid, o_ready, o_ovf}); end
      drive_row(seq_row(8'h90, 16), 7'd16);
      n_cmp++; if (o_data !== seq_beat(8'h90))
         begin n_fail++; $display("FAIL bp_next_beat: got %h want %h", o_data, seq_beat(8'h90)); end
      @(negedge i_clk);
   endtask

   task automatic test_reset_mid_drain();
      i_ready = 1'b0;
      drive_row(seq_row(8'hB0, 40), 7'd40);
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rmd_pre_valid: got %b want 1", o_valid); end
      #2 i_rst = 1'b1;
      #1;
      n_cmp++; if ({o_valid, o_ready, o_ovf} !== 3'b010)
         begin n_fail++; $display("FAIL rmd_in_reset: valid/ready/ovf got %b want 010", {o_valid, o_ready, o_ovf}); end
      @(negedge i_clk);
      i_rst   = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      n_cmp++; if ({o_valid, o_ready} !== 2'b01)
         begin n_fail++; $display("FAIL rmd_after: valid/ready got %b want 01", {o_valid, o_ready}); end
      drive_row(seq_row(8'hC0, 16), 7'd16);
      n_cmp++; if ({o_valid, o_data, o_keep} !== {1'b1, seq_beat(8'hC0), 16'hFFFF})
         begin n_fail++; $display("FAIL rmd_next_beat: valid/data/keep got %b/%h/%h want 1/%h/ffff",
               o_valid, o_data, o_keep, seq_beat(8'hC0)); end
      @(negedge i_clk);
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmd_drained: got %b want 0", o_valid); end
   endtask

   initial begin
      i_rst       = 1'b1;
      i_en        = 1'b0;
      i_col_data  = '0;
      i_row_bytes = '0;
      i_flush     = 1'b0;
      i_ready     = 1'b1;
      @(negedge i_clk);
      test_reset();
      test_two_rows();
      test_full_row();
      test_flush_aligned();
      test_partial_flush();
      test_backpressure();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
